mips_multicycle_ctrl: RTL and testbench

//  Multi-cycle MIPS control unit: the producer side of the ALU control interface (alu_op/funct/opcode/shamt).

---
 rtl/mips_ctrl_pkg.sv | 57 +++++
 rtl/mips_alu_op_enc.sv | 70 +++++++
 rtl/mips_multicycle_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared constants and types for the multi-cycle MIPS control unit
// Purpose: opcode/funct constants, ALU op encodings, FSM state and instruction class enums,
//          trap cause codes, and the legal-funct helper used by the encoder.
// Ports: none (package).
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_SLL = 6'd0;
  localparam logic [5:0] FN_SRL = 6'd2;
  localparam logic [5:0] FN_SRA = 6'd3;
  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  localparam logic [1:0] ALU_OP_ADD   = 2'd0;
  localparam logic [1:0] ALU_OP_AND   = 2'd1;
  localparam logic [1:0] ALU_OP_RTYPE = 2'd2;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_OPCODE  = 2'b01;
  localparam logic [1:0] TRAP_FUNCT   = 2'b10;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE  = 3'd0,
    CLS_RTYPE = 3'd1,
    CLS_IMM   = 3'd2,
    CLS_LW    = 3'd3,
    CLS_SW    = 3'd4,
    CLS_J     = 3'd5
  } instr_class_t;

  function automatic logic funct_legal(input logic [5:0] f);
    case (f)
      FN_SLL, FN_SRL, FN_SRA, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_alu_op_enc.sv
// rtl/mips_alu_op_enc.sv - combinational opcode/funct classifier and ALU op encoder
// Purpose: map an instruction's opcode/funct to its ALU control, class and legality.
// Ports: i_opcode, i_funct        - IR[31:26], IR[5:0]
//        o_alu_op, o_alu_src_imm  - ALU operation and immediate-operand select
//        o_cls                    - instruction class for the FSM
//        o_legal, o_cause         - legality and the trap cause when illegal
module mips_alu_op_enc
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]   i_opcode,
  input  logic [5:0]   i_funct,
  output logic [1:0]   o_alu_op,
  output logic         o_alu_src_imm,
  output instr_class_t o_cls,
  output logic         o_legal,
  output logic [1:0]   o_cause
);

  always_comb begin
    o_alu_op      = ALU_OP_ADD;
    o_alu_src_imm = 1'b0;
    o_cls         = CLS_NONE;
    o_legal       = 1'b0;
    o_cause       = TRAP_OPCODE;
    case (i_opcode)
      OP_RTYPE: begin
        o_alu_op = ALU_OP_RTYPE;
        o_cls    = CLS_RTYPE;
        if (funct_legal(i_funct)) begin
          o_legal = 1'b1;
          o_cause = TRAP_NONE;
        end else begin
          o_cause = TRAP_FUNCT;
        end
      end
      OP_J: begin
        o_cls   = CLS_J;
        o_legal = 1'b1;
        o_cause = TRAP_NONE;
      end
      OP_ADDI: begin
        o_alu_src_imm = 1'b1;
        o_cls         = CLS_IMM;
        o_legal       = 1'b1;
        o_cause       = TRAP_NONE;
      end
      OP_ANDI: begin
        o_alu_op      = ALU_OP_AND;
        o_alu_src_imm = 1'b1;
        o_cls         = CLS_IMM;
        o_legal       = 1'b1;
        o_cause       = TRAP_NONE;
      end
      OP_LW: begin
        o_alu_src_imm = 1'b1;
        o_cls         = CLS_LW;
        o_legal       = 1'b1;
        o_cause       = TRAP_NONE;
      end
      OP_SW: begin
        o_alu_src_imm = 1'b1;
        o_cls         = CLS_SW;
        o_legal       = 1'b1;
        o_cause       = TRAP_NONE;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multi-cycle MIPS control FSM with fetch/mem handshake
// Purpose: fetch over a ready-handshaked port, decode, sequence EXEC/MEM/WB strobes,
//          drive the ALU control interface, trap on illegal code or memory timeout.
// Ports: clk, rst_n (async active-low)
//        mem_ready, mem_rdata         - memory completion and read data
//        mem_req, mem_we, mem_addr_sel- memory request side
//        ir_write, pc_inc, pc_jump    - datapath strobes
//        alu_op/funct/opcode/shamt, alu_src_imm, reg_dst, mem_to_reg, reg_write
//        trap, trap_cause, retired    - status
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_ready,
  input  logic [31:0]      mem_rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_write,
  output logic             pc_inc,
  output logic             pc_jump,
  output logic [1:0]       alu_op,
  output logic [5:0]       alu_funct,
  output logic [5:0]       alu_opcode,
  output logic [4:0]       alu_shamt,
  output logic             alu_src_imm,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned WAIT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
  // Count value at which one more unanswered cycle reaches the limit.
  localparam logic [WAIT_W-1:0] WAIT_LAST = (WAIT_LIMIT > 0) ? WAIT_W'(WAIT_LIMIT - 1) : '0;

  state_t             r_state;
  state_t             w_next;
  state_t             w_view;
  logic [31:0]        r_ir;
  logic [WAIT_W-1:0]  r_wait;
  logic [1:0]         r_cause;
  logic [1:0]         w_cause_next;
  logic [CNT_W-1:0]   r_retired;
  logic               w_load_ir;
  logic               w_retire;
  logic               w_timeout;
  logic               w_alu_phase;

  logic [1:0]         w_enc_alu_op;
  logic               w_enc_imm;
  instr_class_t       w_enc_cls;
  logic               w_enc_legal;
  logic [1:0]         w_enc_cause;

  // IR[25:11] feed only the external datapath (jump target, register fields).
  logic               w_unused_ir;
  assign w_unused_ir = ^r_ir[25:11];

  mips_alu_op_enc u_enc (
    .i_opcode      (r_ir[31:26]),
    .i_funct       (r_ir[5:0]),
    .o_alu_op      (w_enc_alu_op),
    .o_alu_src_imm (w_enc_imm),
    .o_cls         (w_enc_cls),
    .o_legal       (w_enc_legal),
    .o_cause       (w_enc_cause)
  );

  assign w_timeout  = (WAIT_LIMIT != 0) && (r_wait == WAIT_LAST) && !mem_ready;
  // While reset is held the outputs are presented as the all-zero TRAP view so
  // no request escapes before the first real FETCH cycle.
  assign w_view     = rst_n ? r_state : ST_TRAP;
  assign trap       = (r_state == ST_TRAP);
  assign trap_cause = r_cause;
  assign retired    = r_retired;

  always_comb begin
    w_next       = r_state;
    w_cause_next = r_cause;
    w_load_ir    = 1'b0;
    w_retire     = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_inc       = 1'b0;
    pc_jump      = 1'b0;
    alu_op       = ALU_OP_ADD;
    alu_funct    = 6'd0;
    alu_opcode   = 6'd0;
    alu_shamt    = 5'd0;
    alu_src_imm  = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;

    w_alu_phase = (w_view == ST_EXEC) || (w_view == ST_MEM) || (w_view == ST_WB);
    if (w_alu_phase) begin
      alu_op      = w_enc_alu_op;
      alu_src_imm = w_enc_imm;
      alu_funct   = r_ir[5:0];
      alu_opcode  = r_ir[31:26];
      alu_shamt   = r_ir[10:6];
    end

    case (w_view)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          w_load_ir = 1'b1;
          w_next    = ST_DECODE;
        end else if (w_timeout) begin
          w_cause_next = TRAP_TIMEOUT;
          w_next       = ST_TRAP;
        end
      end
      ST_DECODE: begin
        // Fetch strobes are registered (one cycle after the handshake) so that
        // no output depends combinationally on mem_ready. On J the datapath
        // gives pc_jump priority over the coincident pc_inc.
        ir_write = 1'b1;
        pc_inc   = 1'b1;
        if (!w_enc_legal) begin
          w_cause_next = w_enc_cause;
          w_next       = ST_TRAP;
        end else if (w_enc_cls == CLS_J) begin
          pc_jump  = 1'b1;
          w_retire = 1'b1;
          w_next   = ST_FETCH;
        end else begin
          w_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if ((w_enc_cls == CLS_LW) || (w_enc_cls == CLS_SW)) w_next = ST_MEM;
        else                                                 w_next = ST_WB;
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (w_enc_cls == CLS_SW);
        if (mem_ready) begin
          if (w_enc_cls == CLS_SW) begin
            w_retire = 1'b1;
            w_next   = ST_FETCH;
          end else begin
            w_next = ST_WB;
          end
        end else if (w_timeout) begin
          w_cause_next = TRAP_TIMEOUT;
          w_next       = ST_TRAP;
        end
      end
      ST_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (w_enc_cls == CLS_RTYPE);
        mem_to_reg = (w_enc_cls == CLS_LW);
        w_retire   = 1'b1;
        w_next     = ST_FETCH;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_FETCH;
      r_ir      <= 32'd0;
      r_wait    <= '0;
      r_cause   <= TRAP_NONE;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      r_cause <= w_cause_next;
      if (w_load_ir) r_ir <= mem_rdata;
      // Any state change clears the counter, covering entry to FETCH and MEM.
      if (w_next != r_state) begin
        r_wait <= '0;
      end else if (mem_req && !mem_ready && (r_wait != '1)) begin
        r_wait <= r_wait + WAIT_W'(1);
      end
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - directed self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_inc, pc_jump;
  logic [1:0]  alu_op;
  logic [5:0]  alu_funct, alu_opcode;
  logic [4:0]  alu_shamt;
  logic        alu_src_imm, reg_dst, mem_to_reg, reg_write, trap;
  logic [1:0]  trap_cause;
  logic [3:0]  retired;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.CNT_W(4), .WAIT_LIMIT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_write     (ir_write),
    .pc_inc       (pc_inc),
    .pc_jump      (pc_jump),
    .alu_op       (alu_op),
    .alu_funct    (alu_funct),
    .alu_opcode   (alu_opcode),
    .alu_shamt    (alu_shamt),
    .alu_src_imm  (alu_src_imm),
    .reg_dst      (reg_dst),
    .mem_to_reg   (mem_to_reg),
    .reg_write    (reg_write),
    .trap         (trap),
    .trap_cause   (trap_cause),
    .retired      (retired)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lands in a FETCH cycle, completes it with zero wait, ends in the DECODE cycle.
  task automatic go_fetch(input logic [31:0] instr, input logic [3:0] exp_ret);
    @(negedge clk);
    chk("fetch_req", mem_req, 1);
    chk("fetch_sel", mem_addr_sel, 0);
    chk("fetch_we", mem_we, 0);
    chk("fetch_alu_op", alu_op, 0);
    chk("fetch_jump", pc_jump, 0);
    chk("fetch_retired", retired, exp_ret);
    mem_ready = 1'b1;
    mem_rdata = instr;
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    chk("dec_ir_write", ir_write, 1);
    chk("dec_pc_inc", pc_inc, 1);
    chk("dec_req", mem_req, 0);
    chk("dec_alu_op", alu_op, 0);
  endtask

  task automatic run_alu(input logic [31:0] instr, input logic [3:0] exp_ret,
                         input logic [1:0] op, input logic imm, input logic rdst,
                         input logic [5:0] fn, input logic [5:0] opc, input logic [4:0] sh);
    go_fetch(instr, exp_ret);
    chk("dec_jump", pc_jump, 0);
    @(negedge clk);
    chk("exec_alu_op", alu_op, op);
    chk("exec_imm", alu_src_imm, imm);
    chk("exec_funct", alu_funct, fn);
    chk("exec_opcode", alu_opcode, opc);
    chk("exec_shamt", alu_shamt, sh);
    chk("exec_reg_write", reg_write, 0);
    @(negedge clk);
    chk("wb_reg_write", reg_write, 1);
    chk("wb_reg_dst", reg_dst, rdst);
    chk("wb_mem_to_reg", mem_to_reg, 0);
    chk("wb_alu_op", alu_op, op);
    chk("wb_req", mem_req, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_trap", trap, 0);
    chk("rst_cause", trap_cause, 0);
    chk("rst_retired", retired, 0);
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_req", mem_req, 0);
    chk("reset_irw", ir_write, 0);
    chk("reset_reg_write", reg_write, 0);
    chk("reset_trap", trap, 0);
    chk("reset_cause", trap_cause, 0);
    chk("reset_retired", retired, 0);
    rst_n = 1'b1;

    // ADD $8,$9,$10 then SRA $8,$9,2
    run_alu(32'h012A4020, 4'd0, 2'd2, 1'b0, 1'b1, 6'd32, 6'd0, 5'd0);
    run_alu(32'h00094083, 4'd1, 2'd2, 1'b0, 1'b1, 6'd3, 6'd0, 5'd2);

    // LW with three wait cycles; ready on the fourth (limit) cycle completes
    go_fetch(32'h8D090004, 4'd2);
    @(negedge clk);
    chk("lw_exec_op", alu_op, 0);
    chk("lw_exec_imm", alu_src_imm, 1);
    chk("lw_exec_opcode", alu_opcode, 6'd35);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lw_mem_req", mem_req, 1);
      chk("lw_mem_we", mem_we, 0);
      chk("lw_mem_sel", mem_addr_sel, 1);
      chk("lw_mem_op", alu_op, 0);
      chk("lw_mem_imm", alu_src_imm, 1);
    end
    @(negedge clk);
    chk("lw_mem_req_last", mem_req, 1);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("lw_wb_trap", trap, 0);
    chk("lw_wb_reg_write", reg_write, 1);
    chk("lw_wb_mem_to_reg", mem_to_reg, 1);
    chk("lw_wb_reg_dst", reg_dst, 0);
    chk("lw_wb_imm", alu_src_imm, 1);
    chk("lw_wb_req", mem_req, 0);

    // SW zero-wait
    go_fetch(32'hAD090008, 4'd3);
    @(negedge clk);
    chk("sw_exec_op", alu_op, 0);
    chk("sw_exec_imm", alu_src_imm, 1);
    @(negedge clk);
    chk("sw_mem_we", mem_we, 1);
    chk("sw_mem_req", mem_req, 1);
    chk("sw_mem_sel", mem_addr_sel, 1);
    chk("sw_reg_write", reg_write, 0);
    mem_ready = 1'b1;

    // J: pc_jump in DECODE only, retires there
    go_fetch(32'h08000010, 4'd4);
    chk("j_dec_jump", pc_jump, 1);
    chk("j_dec_reg_write", reg_write, 0);

    // Illegal opcode 0x3F
    go_fetch(32'hFC000000, 4'd5);
    chk("ill_dec_jump", pc_jump, 0);
    @(negedge clk);
    chk("ill_trap", trap, 1);
    chk("ill_cause", trap_cause, 2'b01);
    chk("ill_req", mem_req, 0);
    mem_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("ill_hold_req", mem_req, 0);
      chk("ill_hold_trap", trap, 1);
      chk("ill_hold_cause", trap_cause, 2'b01);
      chk("ill_hold_irw", ir_write, 0);
      chk("ill_hold_retired", retired, 5);
    end
    do_reset();

    // NOR (funct 0x27) is an illegal funct
    go_fetch(32'h012A4027, 4'd0);
    @(negedge clk);
    chk("fn_trap", trap, 1);
    chk("fn_cause", trap_cause, 2'b10);
    chk("fn_req", mem_req, 0);
    @(negedge clk);
    chk("fn_hold_req", mem_req, 0);
    do_reset();

    // Memory timeout in MEM: four unanswered cycles then TRAP/11
    go_fetch(32'h8D090004, 4'd0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_mem_req", mem_req, 1);
      chk("to_no_trap", trap, 0);
    end
    @(negedge clk);
    chk("to_trap", trap, 1);
    chk("to_cause", trap_cause, 2'b11);
    chk("to_req", mem_req, 0);
    do_reset();

    // Asynchronous reset in the middle of MEM
    go_fetch(32'h8D090004, 4'd0);
    @(negedge clk);
    @(negedge clk);
    chk("mid_mem_req", mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_sel", mem_addr_sel, 0);
    chk("mid_rst_op", alu_op, 0);
    chk("mid_rst_imm", alu_src_imm, 0);
    chk("mid_rst_reg_write", reg_write, 0);
    chk("mid_rst_retired", retired, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sixteen ADDIs wrap the 4-bit counter; ANDI afterwards sees retired 0
    for (int i = 0; i < 16; i++) begin
      run_alu(32'h21080001, 4'(i), 2'd0, 1'b1, 1'b0, 6'd1, 6'd8, 5'd0);
    end
    run_alu(32'h31080001, 4'd0, 2'd1, 1'b1, 1'b0, 6'd1, 6'd12, 5'd0);
    @(negedge clk);
    chk("final_retired", retired, 1);
    chk("final_req", mem_req, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
